// File: rtl/sng_controller_pkg.sv
// Shared definitions for the stochastic number generator controller:
// data width, LFSR feedback taps, FSM state encoding and the LFSR step function.
package sc_pkg;

    localparam int          DW        = 8;
    // Fibonacci taps for x^8+x^6+x^5+x^4+1 (bits 7,5,4,3 of the shift register)
    localparam logic [7:0]  LFSR_TAPS = 8'hB8;
    localparam logic [7:0]  LFSR_ONE  = 8'h01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [7:0] lfsr_next(input logic [7:0] q);
        return {q[6:0], ^(q & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/sng_controller_lfsr8.sv
// 8-bit maximal-length Fibonacci LFSR with synchronous load and step enable.
module lfsr8
    import sc_pkg::*;
#(
    parameter logic [7:0] SEED = 8'h01
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         load,
    input  logic [DW-1:0] load_val,
    output logic [DW-1:0] q
);

    logic [DW-1:0] q_r;

    // shift register: load wins over step; holds otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_r <= SEED;
        end else if (load) begin
            q_r <= load_val;
        end else if (en) begin
            q_r <= lfsr_next(q_r);
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/sng_controller.sv
// Stochastic bitstream generator: emits LEN bits, each 1 when the LFSR value
// is below the latched operand, and counts the ones produced.
module sng_controller
    import sc_pkg::*;
#(
    parameter int         LEN  = 255,
    parameter logic [7:0] SEED = 8'h01
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] x,
    input  logic          abort,
    input  logic          seed_load,
    input  logic [DW-1:0] seed,
    output logic          busy,
    output logic          bit_valid,
    output logic          bit_out,
    output logic [DW-1:0] ones,
    output logic          done
);

    localparam logic [7:0] LAST_CNT = 8'(LEN - 1);

    state_t        state_r;
    state_t        state_s;
    logic [DW-1:0] x_q_r;
    logic [DW-1:0] ones_r;
    logic [7:0]    cnt_r;
    logic [DW-1:0] lfsr_s;
    logic [DW-1:0] load_val_s;
    logic          accept_s;
    logic          cmp_s;
    logic          lfsr_en_s;
    logic          lfsr_load_s;
    logic          busy_s;
    logic          bit_valid_s;
    logic          bit_out_s;
    logic          done_s;

    assign accept_s    = (state_r == ST_IDLE) && start && !abort;
    assign cmp_s       = (lfsr_s < x_q_r);
    assign lfsr_en_s   = (state_r == ST_RUN);
    assign lfsr_load_s = (state_r == ST_IDLE) && seed_load;
    // a zero seed would lock the LFSR, so it is replaced by 1
    assign load_val_s  = (seed == 8'h00) ? LFSR_ONE : seed;

    lfsr8 #(.SEED(SEED)) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .en       (lfsr_en_s),
        .load     (lfsr_load_s),
        .load_val (load_val_s),
        .q        (lfsr_s)
    );

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // next-state logic; abort outranks both start and run completion
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_s = ST_IDLE;
                end else if (cnt_r == LAST_CNT) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // operand latch, bit counter and ones accumulator
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q_r  <= 8'h00;
            ones_r <= 8'h00;
            cnt_r  <= 8'h00;
        end else if (accept_s) begin
            x_q_r  <= x;
            ones_r <= 8'h00;
            cnt_r  <= 8'h00;
        end else if (state_r == ST_RUN) begin
            x_q_r  <= x_q_r;
            ones_r <= ones_r + {7'd0, cmp_s};
            cnt_r  <= cnt_r + 8'd1;
        end else begin
            x_q_r  <= x_q_r;
            ones_r <= ones_r;
            cnt_r  <= cnt_r;
        end
    end

    // output decode from the state register
    always_comb begin
        busy_s      = 1'b0;
        bit_valid_s = 1'b0;
        bit_out_s   = 1'b0;
        done_s      = 1'b0;
        case (state_r)
            ST_RUN: begin
                busy_s      = 1'b1;
                bit_valid_s = 1'b1;
                bit_out_s   = cmp_s;
            end
            ST_DONE: done_s = 1'b1;
            default: begin
                busy_s      = 1'b0;
                bit_valid_s = 1'b0;
                bit_out_s   = 1'b0;
                done_s      = 1'b0;
            end
        endcase
    end

    assign busy      = busy_s;
    assign bit_valid = bit_valid_s;
    assign bit_out   = bit_out_s;
    assign done      = done_s;
    assign ones      = ones_r;

endmodule

// File: doc/sng_controller.md
SNG_CONTROLLER -- requirements
Module: sng_controller

Interface
REQ-001 Parameter: LEN, 255, bitstream length in cycles per run; legal range 1..255.
REQ-002 Parameter: SEED, 8'h01, LFSR reset/default seed; must be nonzero.
REQ-003 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  in  1  reset, asynchronous, active-high.
REQ-005 Port: start  in  1  request a run; sampled only in IDLE.
REQ-006 Port: x  in  8  binary value to encode; latched on accepted start.
REQ-007 Port: abort  in  1  terminate the current run.
REQ-008 Port: seed_load  in  1  load seed into LFSR; honoured only in IDLE.
REQ-009 Port: seed  in  8  seed value for seed_load.
REQ-010 Port: busy  out  1  high while in RUN.
REQ-011 Port: bit_valid  out  1  high in each cycle that bit_out carries a stream bit.
REQ-012 Port: bit_out  out  1  stochastic bit, 1 when LFSR value < latched x.
REQ-013 Port: ones  out  8  count of 1 bits emitted in the current or last run.
REQ-014 Port: done  out  1  one-cycle pulse after a run's final bit.

Function
REQ-015 FSM states IDLE, RUN, DONE; the module SHALL leave reset in IDLE.
REQ-016 IDLE->RUN when start=1 and abort=0; same edge latches x into x_q and clears ones and the bit counter.
REQ-017 In RUN, each cycle SHALL output bit_valid=1 and bit_out=(lfsr<x_q) as unsigned 8-bit compare; lfsr advances and the bit counter increments on the same edge.
REQ-018 ones SHALL increment on every RUN edge where bit_out=1; it SHALL hold its value in IDLE and DONE until the next accepted start.
REQ-019 RUN->DONE on the edge where the LEN-th bit is emitted; first bit in cycle 1 after the start edge, last bit in cycle LEN, done=1 in cycle LEN+1.
REQ-020 DONE->IDLE unconditionally after one cycle; start is ignored in RUN and DONE.
REQ-021 abort=1 in RUN SHALL go to IDLE next edge with no done pulse; ones holds the partial count; abort has priority over start in IDLE.
REQ-022 LFSR: 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1, period 255, never 0; it advances only in RUN and continues from its last value on the next run.
REQ-023 seed_load in IDLE SHALL load seed into the LFSR; seed=0 SHALL load 8'h01; seed_load outside IDLE is ignored.
REQ-024 bit_valid, bit_out and busy SHALL be 0 outside RUN; done SHALL be 0 outside DONE.
REQ-025 With LEN=255 the run covers every nonzero LFSR value once, so ones SHALL equal max(x-1,0) regardless of starting LFSR state.

Reset
REQ-026 rst=1 SHALL immediately force state IDLE, lfsr=SEED, x_q=0, ones=0, bit counter=0, and busy, bit_valid, bit_out and done to 0.
REQ-027 Reset asserted mid-RUN SHALL abandon the run with no done pulse; the first start after release begins a fresh run.

Structure
REQ-028 Shared package sc_pkg SHALL hold the data width (8), the LFSR tap constant, and the FSM state enum.
REQ-029 The LFSR SHALL be a separate sub-module lfsr8 with enable, load and load-value inputs; compare, counters and FSM stay in sng_controller.

Verification
REQ-030 Reset, then start with x=8'd128 and LEN=255 -> 255 bit_valid cycles, done in cycle 256, ones=127.
REQ-031 x=0 -> ones=0; x=255 -> ones=254; x=1 -> ones=0; bit_out stays 0 throughout for x=0.
REQ-032 seed_load with seed=0 in IDLE, then run LEN=8 -> bit_out matches the reference LFSR sequence starting at 8'h01.
REQ-033 abort asserted in cycle 10 of a run -> busy low next cycle, no done, ones equals the count of 1s in bits 1..9 (or 1..10 if abort is sampled after the tenth bit, per REQ-021 timing); start pulses during RUN or DONE are ignored.
REQ-034 rst asserted mid-RUN, asynchronously between edges -> all outputs 0 immediately, lfsr=SEED; the next run reproduces the from-reset bit sequence.
REQ-035 start and abort asserted together in IDLE -> stays IDLE, busy=0, ones unchanged.
